// File: rtl/rggen_rtl_pkg.sv
// Shared register-bus types used by the bus bridges, the arbiter and the register-block adapter.
package rggen_rtl_pkg;

    typedef enum logic [1:0] {
        RGGEN_READ          = 2'b10,
        RGGEN_POSTED_WRITE  = 2'b01,
        RGGEN_WRITE         = 2'b11
    } rggen_access;

    typedef enum logic [1:0] {
        RGGEN_OKAY          = 2'b00,
        RGGEN_EXOKAY        = 2'b01,
        RGGEN_SLAVE_ERROR   = 2'b10,
        RGGEN_DECODE_ERROR  = 2'b11
    } rggen_status;

    typedef enum logic {
        RGGEN_ARB_IDLE,
        RGGEN_ARB_BUSY
    } rggen_arb_state;

endpackage

// File: rtl/rggen_rr_arbiter.sv
// Round-robin request arbiter with a rotating priority pointer.
// The pointer advances past the completing winner whenever i_update is asserted.
module rggen_rr_arbiter #(
    parameter int N = 2
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_request,
    input  logic         i_update,
    input  logic [N-1:0] i_winner,
    output logic [N-1:0] o_grant
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;

    logic [PW-1:0] r_pointer;
    logic [PW-1:0] w_winner_index;
    logic [PW-1:0] w_next_pointer;

    // Search starts at the pointer and wraps modulo N; first requester found wins.
    always_comb begin
        logic w_found;
        int   w_sum;
        o_grant = '0;
        w_found = 1'b0;
        w_sum   = 0;
        for (int i = 0; i < N; i++) begin
            w_sum = int'(r_pointer) + i;
            if (w_sum >= N) begin
                w_sum = w_sum - N;
            end
            if (!w_found && i_request[PW'(w_sum)]) begin
                o_grant[PW'(w_sum)] = 1'b1;
                w_found             = 1'b1;
            end
        end
    end

    always_comb begin
        w_winner_index = '0;
        for (int i = 0; i < N; i++) begin
            if (i_winner[i]) begin
                w_winner_index = PW'(i);
            end
        end
    end

    assign w_next_pointer = (w_winner_index == PW'(N - 1)) ? '0 : w_winner_index + PW'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pointer <= '0;
        end else if (i_update) begin
            r_pointer <= w_next_pointer;
        end
    end

endmodule

// File: rtl/rggen_bus_arbiter.sv
// Shares one register-bus slave port among HOSTS masters with round-robin arbitration;
// the grant is held from acceptance until the downstream ready and responses go only to the owner.
module rggen_bus_arbiter
    import rggen_rtl_pkg::*;
#(
    parameter int HOSTS         = 2,
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [HOSTS-1:0]           i_valid,
    input  rggen_access                i_access     [HOSTS],
    input  logic [ADDRESS_WIDTH-1:0]   i_address    [HOSTS],
    input  logic [BUS_WIDTH-1:0]       i_write_data [HOSTS],
    input  logic [BUS_WIDTH/8-1:0]     i_strobe     [HOSTS],
    output logic [HOSTS-1:0]           o_ready,
    output rggen_status                o_status     [HOSTS],
    output logic [BUS_WIDTH-1:0]       o_read_data  [HOSTS],
    output logic [HOSTS-1:0]           o_grant,
    output logic                       o_bus_valid,
    output rggen_access                o_bus_access,
    output logic [ADDRESS_WIDTH-1:0]   o_bus_address,
    output logic [BUS_WIDTH-1:0]       o_bus_write_data,
    output logic [BUS_WIDTH/8-1:0]     o_bus_strobe,
    input  logic                       i_bus_ready,
    input  rggen_status                i_bus_status,
    input  logic [BUS_WIDTH-1:0]       i_bus_read_data
);
    rggen_arb_state             r_state;
    logic [HOSTS-1:0]           r_grant;
    logic [HOSTS-1:0]           w_arb_grant;
    logic [HOSTS-1:0]           w_grant;
    logic                       w_bus_valid;
    logic                       w_complete;
    logic [1:0]                 w_access;
    logic [ADDRESS_WIDTH-1:0]   w_address;
    logic [BUS_WIDTH-1:0]       w_write_data;
    logic [BUS_WIDTH/8-1:0]     w_strobe;

    rggen_rr_arbiter #(
        .N  (HOSTS)
    ) u_rr_arbiter (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .i_request  (i_valid),
        .i_update   (w_complete),
        .i_winner   (w_grant),
        .o_grant    (w_arb_grant)
    );

    // Reset gates the grant directly so the bus drops the moment i_rst_n falls.
    assign w_grant     = (!i_rst_n) ? '0 :
                         (r_state == RGGEN_ARB_BUSY) ? r_grant : w_arb_grant;
    assign w_bus_valid = |(i_valid & w_grant);
    assign w_complete  = w_bus_valid & i_bus_ready;

    always_comb begin
        w_access     = '0;
        w_address    = '0;
        w_write_data = '0;
        w_strobe     = '0;
        for (int j = 0; j < HOSTS; j++) begin
            if (w_bus_valid && w_grant[j]) begin
                w_access     = w_access     | i_access[j];
                w_address    = w_address    | i_address[j];
                w_write_data = w_write_data | i_write_data[j];
                w_strobe     = w_strobe     | i_strobe[j];
            end
        end
    end

    assign o_grant          = w_grant;
    assign o_bus_valid      = w_bus_valid;
    assign o_bus_access     = rggen_access'(w_access);
    assign o_bus_address    = w_address;
    assign o_bus_write_data = w_write_data;
    assign o_bus_strobe     = w_strobe;

    always_comb begin
        o_ready = '0;
        for (int j = 0; j < HOSTS; j++) begin
            o_ready[j]     = w_grant[j] & w_complete;
            o_status[j]    = w_grant[j] ? i_bus_status : RGGEN_OKAY;
            o_read_data[j] = w_grant[j] ? i_bus_read_data : '0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= RGGEN_ARB_IDLE;
            r_grant <= '0;
        end else begin
            case (r_state)
                RGGEN_ARB_IDLE: begin
                    if (w_bus_valid && !i_bus_ready) begin
                        r_state <= RGGEN_ARB_BUSY;
                        r_grant <= w_arb_grant;
                    end
                end
                RGGEN_ARB_BUSY: begin
                    if (i_bus_ready) begin
                        r_state <= RGGEN_ARB_IDLE;
                        r_grant <= '0;
                    end
                end
                default: begin
                    r_state <= RGGEN_ARB_IDLE;
                    r_grant <= '0;
                end
            endcase
        end
    end

`ifdef RGGEN_ENABLE_SVA
    a_grant_onehot: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        $onehot0(o_grant));
    a_ready_granted: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        ((o_ready & ~o_grant) == '0));
    a_valid_held: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        (o_bus_valid && !i_bus_ready) |=> o_bus_valid);
    a_ready_with_valid: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        i_bus_ready |-> o_bus_valid);
`endif

endmodule

// File: tb/tb_rggen_bus_arbiter.sv
// Scoreboard bench for rggen_bus_arbiter: per-host request queues, a latency-programmable
// downstream slave, and a monitor that pops expected transactions as the DUT presents them.
module tb_rggen_bus_arbiter;
    import rggen_rtl_pkg::*;

    localparam int HOSTS = 3;
    localparam int AW    = 16;
    localparam int BW    = 32;
    localparam int SW    = BW / 8;

    typedef struct {
        int          host;
        rggen_access acc;
        logic [AW-1:0] addr;
        logic [BW-1:0] wdata;
        logic [SW-1:0] strb;
        rggen_status st;
        logic [BW-1:0] rdata;
    } txn_t;

    logic               clk;
    logic               rst_n;
    logic [HOSTS-1:0]   valid;
    rggen_access        acc   [HOSTS];
    logic [AW-1:0]      addr  [HOSTS];
    logic [BW-1:0]      wdata [HOSTS];
    logic [SW-1:0]      strb  [HOSTS];
    logic [HOSTS-1:0]   ready;
    rggen_status        st    [HOSTS];
    logic [BW-1:0]      rdata [HOSTS];
    logic [HOSTS-1:0]   grant;
    logic               bus_valid;
    rggen_access        bus_acc;
    logic [AW-1:0]      bus_addr;
    logic [BW-1:0]      bus_wdata;
    logic [SW-1:0]      bus_strb;
    logic               bus_ready;
    rggen_status        bus_st;
    logic [BW-1:0]      bus_rdata;

    int   lat      = 0;
    int   wait_cnt = 0;
    int   checks   = 0;
    int   errors   = 0;
    txn_t hq [HOSTS][$];
    txn_t expq[$];

    rggen_bus_arbiter #(
        .HOSTS          (HOSTS),
        .ADDRESS_WIDTH  (AW),
        .BUS_WIDTH      (BW)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_valid            (valid),
        .i_access           (acc),
        .i_address          (addr),
        .i_write_data       (wdata),
        .i_strobe           (strb),
        .o_ready            (ready),
        .o_status           (st),
        .o_read_data        (rdata),
        .o_grant            (grant),
        .o_bus_valid        (bus_valid),
        .o_bus_access       (bus_acc),
        .o_bus_address      (bus_addr),
        .o_bus_write_data   (bus_wdata),
        .o_bus_strobe       (bus_strb),
        .i_bus_ready        (bus_ready),
        .i_bus_status       (bus_st),
        .i_bus_read_data    (bus_rdata)
    );

    // Downstream slave: completes after lat waiting cycles; data/status fixed by address.
    assign bus_ready = bus_valid && (wait_cnt >= lat);
    assign bus_rdata = (bus_addr == 16'h0020) ? 32'h12345678 : {16'hC0DE, bus_addr};
    assign bus_st    = (bus_addr == 16'h0030) ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send(input int h, input rggen_access a, input logic [AW-1:0] ad,
                        input logic [BW-1:0] wd, input logic [SW-1:0] sb,
                        input rggen_status es, input logic [BW-1:0] er);
        txn_t t;
        t.host = h; t.acc = a; t.addr = ad; t.wdata = wd; t.strb = sb; t.st = es; t.rdata = er;
        hq[h].push_back(t);
        expq.push_back(t);
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        while ((expq.size() != 0) && (n < max_cycles)) begin
            @(posedge clk); #2;
            n++;
        end
        if (expq.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d transactions still pending, expected 0", expq.size());
            expq.delete();
            for (int h = 0; h < HOSTS; h++) hq[h].delete();
        end
    endtask

    // Host drivers and slave wait counter: sample at negedge, update just after posedge.
    initial begin
        logic [HOSTS-1:0] s_rdy;
        logic s_bv;
        logic s_br;
        valid = '0;
        for (int h = 0; h < HOSTS; h++) begin
            acc[h] = RGGEN_READ; addr[h] = '0; wdata[h] = '0; strb[h] = '0;
        end
        forever begin
            @(negedge clk);
            s_rdy = ready;
            s_bv  = bus_valid;
            s_br  = bus_ready;
            @(posedge clk); #1;
            wait_cnt = (s_bv && !s_br) ? wait_cnt + 1 : 0;
            for (int h = 0; h < HOSTS; h++) begin
                if (s_rdy[h] && (hq[h].size() > 0)) void'(hq[h].pop_front());
                if (hq[h].size() > 0) begin
                    valid[h] = 1'b1;
                    acc[h]   = hq[h][0].acc;
                    addr[h]  = hq[h][0].addr;
                    wdata[h] = hq[h][0].wdata;
                    strb[h]  = hq[h][0].strb;
                end else begin
                    valid[h] = 1'b0;
                    acc[h]   = RGGEN_READ;
                    addr[h]  = '0;
                    wdata[h] = '0;
                    strb[h]  = '0;
                end
            end
        end
    end

    // Monitor
    initial begin
        txn_t e;
        logic [HOSTS-1:0] oh;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus_valid) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_bus_valid", 64'(bus_valid), 64'(0));
                    end else begin
                        e  = expq[0];
                        oh = HOSTS'(1) << e.host;
                        chk("grant", 64'(grant), 64'(oh));
                        chk("bus_address", 64'(bus_addr), 64'(e.addr));
                        chk("bus_access", 64'(bus_acc), 64'(e.acc));
                        chk("bus_write_data", 64'(bus_wdata), 64'(e.wdata));
                        chk("bus_strobe", 64'(bus_strb), 64'(e.strb));
                    end
                end else begin
                    chk("idle_grant", 64'(grant), 64'(0));
                    chk("idle_bus_payload", {16'(bus_addr), 32'(bus_wdata), 4'(bus_strb), 2'(bus_acc), 10'd0}, 64'(0));
                end
                if (ready != '0) begin
                    if (expq.size() == 0) begin
                        chk("unexpected_ready", 64'(ready), 64'(0));
                    end else begin
                        e  = expq.pop_front();
                        oh = HOSTS'(1) << e.host;
                        chk("ready", 64'(ready), 64'(oh));
                        for (int j = 0; j < HOSTS; j++) begin
                            chk($sformatf("status[%0d]", j), 64'(st[j]),
                                (j == e.host) ? 64'(e.st) : 64'(0));
                            chk($sformatf("read_data[%0d]", j), 64'(rdata[j]),
                                (j == e.host) ? 64'(e.rdata) : 64'(0));
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_bus_valid", 64'(bus_valid), 64'(0));
        chk("reset_grant", 64'(grant), 64'(0));
        chk("reset_ready", 64'(ready), 64'(0));
        rst_n = 1'b1;

        // Single write, same-cycle completion; pointer moves to 1.
        lat = 0;
        @(posedge clk); #2;
        send(0, RGGEN_WRITE, 16'h0010, 32'hDEADBEEF, 4'hF, RGGEN_OKAY, 32'hC0DE0010);
        drain(20);
        // Pointer at 1 lets host1 win over host0; host2 alone then moves pointer to 0.
        send(1, RGGEN_READ,  16'h0014, 32'h0,        4'h0, RGGEN_OKAY, 32'hC0DE0014);
        send(0, RGGEN_WRITE, 16'h0018, 32'h11112222, 4'h3, RGGEN_OKAY, 32'hC0DE0018);
        drain(20);
        send(2, RGGEN_POSTED_WRITE, 16'h001C, 32'h33334444, 4'hC, RGGEN_OKAY, 32'hC0DE001C);
        drain(20);

        // Two hosts contending with 3-cycle slave latency: strict alternation.
        lat = 3;
        send(0, RGGEN_WRITE, 16'h0100, 32'hA0A0A0A0, 4'hF, RGGEN_OKAY, 32'hC0DE0100);
        send(1, RGGEN_WRITE, 16'h0104, 32'hB1B1B1B1, 4'hF, RGGEN_OKAY, 32'hC0DE0104);
        send(0, RGGEN_WRITE, 16'h0108, 32'hA2A2A2A2, 4'hF, RGGEN_OKAY, 32'hC0DE0108);
        send(1, RGGEN_WRITE, 16'h010C, 32'hB3B3B3B3, 4'hF, RGGEN_OKAY, 32'hC0DE010C);
        drain(60);

        // Pointer at 2 with all hosts valid: 2, then wrap to 0, then 1.
        lat = 1;
        send(2, RGGEN_READ, 16'h0200, 32'h0, 4'h0, RGGEN_OKAY, 32'hC0DE0200);
        send(0, RGGEN_READ, 16'h0204, 32'h0, 4'h0, RGGEN_OKAY, 32'hC0DE0204);
        send(1, RGGEN_READ, 16'h0208, 32'h0, 4'h0, RGGEN_OKAY, 32'hC0DE0208);
        drain(40);

        // Host1 read arrives while host0 is BUSY; served only afterwards.
        lat = 2;
        send(0, RGGEN_WRITE, 16'h0040, 32'hCAFEF00D, 4'hF, RGGEN_OKAY, 32'hC0DE0040);
        @(posedge clk); #2;
        send(1, RGGEN_READ,  16'h0020, 32'h0,        4'h0, RGGEN_OKAY, 32'h12345678);
        drain(40);

        // Error response routed to host1 only.
        lat = 1;
        send(1, RGGEN_READ, 16'h0030, 32'h0, 4'h0, RGGEN_SLAVE_ERROR, 32'hC0DE0030);
        drain(20);

        // Host0 completion leaves the pointer at 1 before the reset scenario.
        lat = 0;
        send(0, RGGEN_WRITE, 16'h0070, 32'h01020304, 4'h1, RGGEN_OKAY, 32'hC0DE0070);
        drain(20);

        // Reset while host1 is BUSY.
        lat = 20;
        send(1, RGGEN_WRITE, 16'h0050, 32'h0BADF00D, 4'hF, RGGEN_OKAY, 32'hC0DE0050);
        repeat (4) @(posedge clk);
        #2;
        chk("busy_grant", 64'(grant), 64'(3'b010));
        chk("busy_bus_valid", 64'(bus_valid), 64'(1));
        rst_n = 1'b0;
        #1;
        chk("async_reset_bus_valid", 64'(bus_valid), 64'(0));
        chk("async_reset_grant", 64'(grant), 64'(0));
        chk("async_reset_ready", 64'(ready), 64'(0));
        expq.delete();
        for (int h = 0; h < HOSTS; h++) hq[h].delete();
        lat = 1;
        send(0, RGGEN_WRITE, 16'h0060, 32'h55AA55AA, 4'hF, RGGEN_OKAY, 32'hC0DE0060);
        send(1, RGGEN_WRITE, 16'h0050, 32'h0BADF00D, 4'hF, RGGEN_OKAY, 32'hC0DE0050);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        drain(40);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
